// File: rtl/instr_register_pkg.sv
// Shared types for the pipelined instruction register: opcode encoding.
package instr_register_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

endpackage

// File: rtl/ir_alu.sv
// Combinational signed ALU placed between the S1 and S2 pipeline stages.
// Operands are sign-extended to 2*OP_W so no result can overflow.
module ir_alu
    import instr_register_pkg::*;
#(
    parameter int OP_W = 32
) (
    input  opcode_t           i_opc,
    input  logic [OP_W-1:0]   i_op_a,
    input  logic [OP_W-1:0]   i_op_b,
    output logic [2*OP_W-1:0] o_result,
    output logic              o_div_err
);

    logic signed [2*OP_W-1:0] w_a_ext;
    logic signed [2*OP_W-1:0] w_b_ext;
    logic signed [2*OP_W-1:0] w_div_b;
    logic                     w_b_zero;

    assign w_a_ext  = {{OP_W{i_op_a[OP_W-1]}}, i_op_a};
    assign w_b_ext  = {{OP_W{i_op_b[OP_W-1]}}, i_op_b};
    assign w_b_zero = (i_op_b == {OP_W{1'b0}});
    // Divisor forced to 1 on zero so the divider never sees a zero operand.
    assign w_div_b  = w_b_zero ? {{(2*OP_W-1){1'b0}}, 1'b1} : w_b_ext;

    // Opcode decode and arithmetic.
    always_comb begin
        o_result  = {(2*OP_W){1'b0}};
        o_div_err = 1'b0;
        case (i_opc)
            ZERO:  o_result = {(2*OP_W){1'b0}};
            PASSA: o_result = w_a_ext;
            PASSB: o_result = w_b_ext;
            ADD:   o_result = w_a_ext + w_b_ext;
            SUB:   o_result = w_a_ext - w_b_ext;
            MULT:  o_result = w_a_ext * w_b_ext;
            DIV: begin
                if (w_b_zero) begin
                    o_result  = {(2*OP_W){1'b0}};
                    o_div_err = 1'b1;
                end else begin
                    o_result  = w_a_ext / w_div_b;
                    o_div_err = 1'b0;
                end
            end
            MOD: begin
                if (w_b_zero) begin
                    o_result  = {(2*OP_W){1'b0}};
                    o_div_err = 1'b1;
                end else begin
                    o_result  = w_a_ext % w_div_b;
                    o_div_err = 1'b0;
                end
            end
            default: begin
                o_result  = {(2*OP_W){1'b0}};
                o_div_err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_register_pipe.sv
// DEPTH-entry instruction register fed by a two-stage ALU pipeline, with a registered read port.
// Optional macro INSTR_REG_VALID_TRACK_EN adds per-entry valid bits.
module instr_register_pipe
    import instr_register_pkg::*;
#(
    parameter int OP_W   = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] write_pointer,
    input  opcode_t           opcode,
    input  logic [OP_W-1:0]   operand_a,
    input  logic [OP_W-1:0]   operand_b,
    input  logic [ADDR_W-1:0] read_pointer,
    output logic [2:0]        rd_opc,
    output logic [OP_W-1:0]   rd_op_a,
    output logic [OP_W-1:0]   rd_op_b,
    output logic [2*OP_W-1:0] rd_result,
    output logic              rd_div_err,
    output logic              rd_valid,
    output logic [1:0]        wr_inflight
);

    typedef struct packed {
        opcode_t              opc;
        logic [OP_W-1:0]      op_a;
        logic [OP_W-1:0]      op_b;
        logic [2*OP_W-1:0]    result;
        logic                 div_err;
    } entry_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    opcode_t           r_s1_opc;
    logic [OP_W-1:0]   r_s1_a;
    logic [OP_W-1:0]   r_s1_b;
    logic              r_s2_valid;
    logic [ADDR_W-1:0] r_s2_addr;
    entry_t            r_s2_entry;
    entry_t            r_mem [DEPTH];

    logic [2*OP_W-1:0] w_alu_result;
    logic              w_alu_div_err;
    logic              w_wr_en;
    logic              w_rd_in_range;

    ir_alu #(.OP_W(OP_W)) u_alu (
        .i_opc     (r_s1_opc),
        .i_op_a    (r_s1_a),
        .i_op_b    (r_s1_b),
        .o_result  (w_alu_result),
        .o_div_err (w_alu_div_err)
    );

    assign w_wr_en       = r_s2_valid && ({1'b0, r_s2_addr} < DEPTH_L);
    assign w_rd_in_range = ({1'b0, read_pointer} < DEPTH_L);
    assign wr_inflight   = {r_s2_valid, r_s1_valid};

    // S1 request capture and S2 ALU result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= {ADDR_W{1'b0}};
            r_s1_opc   <= ZERO;
            r_s1_a     <= {OP_W{1'b0}};
            r_s1_b     <= {OP_W{1'b0}};
            r_s2_valid <= 1'b0;
            r_s2_addr  <= {ADDR_W{1'b0}};
            r_s2_entry <= '0;
        end else begin
            r_s1_valid <= load_en;
            if (load_en) begin
                r_s1_addr <= write_pointer;
                r_s1_opc  <= opcode;
                r_s1_a    <= operand_a;
                r_s1_b    <= operand_b;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_addr  <= r_s1_addr;
                r_s2_entry <= '{opc: r_s1_opc, op_a: r_s1_a, op_b: r_s1_b,
                               result: w_alu_result, div_err: w_alu_div_err};
            end
        end
    end

    // Array write-back from S2; out-of-range addresses are dropped here.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_s2_addr] <= r_s2_entry;
        end
    end

`ifdef INSTR_REG_VALID_TRACK_EN
    logic [DEPTH-1:0] r_vld;

    // Per-entry written flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= {DEPTH{1'b0}};
        end else if (w_wr_en) begin
            r_vld[r_s2_addr] <= 1'b1;
        end
    end
`endif

    // Registered read port; a same-edge write-back is not forwarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_opc     <= 3'd0;
            rd_op_a    <= {OP_W{1'b0}};
            rd_op_b    <= {OP_W{1'b0}};
            rd_result  <= {(2*OP_W){1'b0}};
            rd_div_err <= 1'b0;
            rd_valid   <= 1'b0;
`ifdef INSTR_REG_VALID_TRACK_EN
        end else if (w_rd_in_range && r_vld[read_pointer]) begin
`else
        end else if (w_rd_in_range) begin
`endif
            rd_opc     <= r_mem[read_pointer].opc;
            rd_op_a    <= r_mem[read_pointer].op_a;
            rd_op_b    <= r_mem[read_pointer].op_b;
            rd_result  <= r_mem[read_pointer].result;
            rd_div_err <= r_mem[read_pointer].div_err;
            rd_valid   <= 1'b1;
        end else begin
            rd_opc     <= 3'd0;
            rd_op_a    <= {OP_W{1'b0}};
            rd_op_b    <= {OP_W{1'b0}};
            rd_result  <= {(2*OP_W){1'b0}};
            rd_div_err <= 1'b0;
            rd_valid   <= 1'b0;
        end
    end

endmodule
